fifo_wr_arbiter: RTL

- Shares the single write port of the async FIFO's write domain between NUM_REQ producers.
- Round-robin grant with bounded bursts.
- Drives w_inc/w_data into the FIFO write-pointer/full logic and honours w_full, so no producer can overflow the FIFO or starve the others.
- Lives entirely in the w_clk domain.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, arbiter state encoding and helpers for the
// async FIFO write-domain logic.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: first set req after last_owner, wrapping.
// Purely combinational; returns one-hot and index forms of the pick.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic [NUM_REQ-1:0] sel_oh,
  output logic [IW-1:0]      sel_idx,
  output logic               req_any
);

  localparam logic [IW:0] N_W = (IW+1)'(NUM_REQ);

  logic [IW:0]   j;
  logic [IW-1:0] jj;
  logic          found;

  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    found   = 1'b0;
    j       = '0;
    jj      = '0;
    req_any = |req;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = {1'b0, last_owner} + (IW+1)'(k);
      if (j >= N_W) j = j - N_W;
      jj = j[IW-1:0];
      if (!found && req[jj]) begin
        found       = 1'b1;
        sel_oh[jj]  = 1'b1;
        sel_idx     = jj;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter for the FIFO write port.
// Define FIFO_WR_ARB_STALL_CNT_EN to add the stall_cnt output.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                          w_clk,
  input  logic                          w_reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          w_full,
  output logic                          w_inc,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int IW = clog2(NUM_REQ);
  localparam int BW = clog2(MAX_BURST) + 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  arb_state_t state, state_nxt;

  logic [NUM_REQ-1:0] grant_nxt;
  logic [IW-1:0]      owner, owner_nxt;
  logic [IW-1:0]      last_owner, last_nxt;
  logic [BW-1:0]      burst_cnt, burst_nxt;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               own_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .sel_oh     (pick_oh),
    .sel_idx    (pick_idx),
    .req_any    (pick_any)
  );

  assign own_req = req[owner];

  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      burst_cnt  <= '0;
      last_owner <= LAST_IDX;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      burst_cnt  <= burst_nxt;
      last_owner <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner;
    burst_nxt = burst_cnt;
    last_nxt  = last_owner;
    w_inc     = 1'b0;
    ack       = '0;
    w_data    = '0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          grant_nxt = pick_oh;
          owner_nxt = pick_idx;
          burst_nxt = '0;
        end
      end
      GRANT: begin
        busy   = 1'b1;
        w_data = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
        w_inc  = own_req & ~w_full;
        ack    = grant & {NUM_REQ{w_inc}};
        if (w_inc) burst_nxt = burst_cnt + 1'b1;
        // a stalled final beat holds the grant until it lands
        if (!own_req || (w_inc && burst_cnt == LAST_BEAT)) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      stall_cnt <= '0;
    end else if (state == GRANT && own_req && w_full &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
